// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and SDA drive constants
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic SDA_REL = 1'b1;
    localparam logic SDA_ACK = 1'b0;

endpackage

// File: rtl/i2c_shift_unit.sv
// rtl/i2c_shift_unit.sv - I2C byte shifter: transmit/receive one word plus the ACK slot
module i2c_shift_unit
    import i2c_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              dbit,
    input  logic              mode,
    input  logic              ack_en,
    input  logic              abort,
    input  logic [DATA_W-1:0] Data,
    input  logic              iSDA,
    output logic              oSDA,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              ack_ok
);

    localparam int CNT_W = $clog2(DATA_W);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] sreg;
    logic [DATA_W-1:0] sreg_shift;
    logic [DATA_W-1:0] rx_q;
    logic              mode_q;
    logic              ack_en_q;
    logic              sda_q;
    logic              ack_ok_q;
    logic              bit_in;

    // Bit that goes on the wire first from a given shift-register image.
    function automatic logic head(input logic [DATA_W-1:0] v);
        if (MSB_FIRST != 0)
            return v[DATA_W-1];
        else
            return v[0];
    endfunction

    // One register serves both directions: transmit shifts zeros in, receive shifts iSDA in.
    always_comb begin
        bit_in = mode_q ? iSDA : 1'b0;
        if (MSB_FIRST != 0)
            sreg_shift = {sreg[DATA_W-2:0], bit_in};
        else
            sreg_shift = {bit_in, sreg[DATA_W-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (go) state_nxt = ST_SHIFT;
            ST_SHIFT: if (dbit && (cnt == '0)) state_nxt = ST_ACK;
            ST_ACK:   if (dbit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (abort)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sreg     <= '0;
            rx_q     <= '0;
            mode_q   <= 1'b0;
            ack_en_q <= 1'b0;
            sda_q    <= SDA_REL;
            ack_ok_q <= 1'b0;
        end else if (abort) begin
            sda_q <= SDA_REL;
        end else begin
            case (state)
                ST_IDLE: begin
                    sda_q <= SDA_REL;
                    if (go) begin
                        sreg     <= Data;
                        mode_q   <= mode;
                        ack_en_q <= ack_en;
                        cnt      <= CNT_W'(DATA_W - 1);
                        ack_ok_q <= 1'b0;
                        sda_q    <= mode ? SDA_REL : head(Data);
                    end
                end
                ST_SHIFT: begin
                    if (dbit) begin
                        sreg <= sreg_shift;
                        if (cnt == '0) begin
                            if (mode_q) begin
                                rx_q  <= sreg_shift;
                                sda_q <= ack_en_q ? SDA_ACK : SDA_REL;
                            end else begin
                                sda_q <= SDA_REL;
                            end
                        end else begin
                            cnt   <= cnt - CNT_W'(1);
                            sda_q <= mode_q ? SDA_REL : head(sreg_shift);
                        end
                    end
                end
                ST_ACK: begin
                    if (dbit) begin
                        sda_q <= SDA_REL;
                        if (!mode_q)
                            ack_ok_q <= ~iSDA;
                    end
                end
                ST_DONE: begin
                    sda_q <= SDA_REL;
                end
                default: begin
                    sda_q <= SDA_REL;
                end
            endcase
        end
    end

    assign oSDA    = sda_q;
    assign rx_data = rx_q;
    assign ack_ok  = ack_ok_q;
    assign busy    = (state == ST_SHIFT) || (state == ST_ACK);
    assign done    = (state == ST_DONE);

endmodule

// File: tb/tb_i2c_shift_unit.sv
// tb/tb_i2c_shift_unit.sv - directed self-checking bench for i2c_shift_unit
module tb_i2c_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        go8, dbit8, go16, dbit16;
    logic        mode, ack_en, abort, iSDA;
    logic [7:0]  data8;
    logic [15:0] data16;
    logic        o8, busy8, done8, ackok8;
    logic [7:0]  rx8;
    logic        o16, busy16, done16, ackok16;
    logic [15:0] rx16;
    logic [15:0] exp16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    i2c_shift_unit #(.DATA_W(8), .MSB_FIRST(1)) dut8 (
        .clk(clk), .rst(rst), .go(go8), .dbit(dbit8), .mode(mode),
        .ack_en(ack_en), .abort(abort), .Data(data8), .iSDA(iSDA),
        .oSDA(o8), .rx_data(rx8), .busy(busy8), .done(done8), .ack_ok(ackok8)
    );

    i2c_shift_unit #(.DATA_W(16), .MSB_FIRST(0)) dut16 (
        .clk(clk), .rst(rst), .go(go16), .dbit(dbit16), .mode(mode),
        .ack_en(ack_en), .abort(abort), .Data(data16), .iSDA(iSDA),
        .oSDA(o16), .rx_data(rx16), .busy(busy16), .done(done16), .ack_ok(ackok16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks dut8 through bits [from,to): checks the driven bit, that it holds
    // over an idle cycle, then strobes dbit with the given receive bit on iSDA.
    task automatic shift8(input logic [7:0] exp_o, input logic [7:0] in_bits,
                          input int from, input int to);
        for (int i = from; i < to; i++) begin
            chk($sformatf("bit%0d", i), {31'd0, o8}, {31'd0, exp_o[7-i]});
            step();
            chk($sformatf("hold%0d", i), {31'd0, o8}, {31'd0, exp_o[7-i]});
            chk("busy_shift", {31'd0, busy8}, 32'd1);
            iSDA  = in_bits[7-i];
            dbit8 = 1'b1;
            step();
            dbit8 = 1'b0;
            chk("no_done_shift", {31'd0, done8}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; go8 = 1'b0; dbit8 = 1'b0; go16 = 1'b0; dbit16 = 1'b0;
        mode = 1'b0; ack_en = 1'b0; abort = 1'b0; iSDA = 1'b1;
        data8 = 8'h00; data16 = 16'h0000; exp16 = 16'hBEEF;
        step();
        step();
        rst = 1'b0;

        chk("rst_osda8",  {31'd0, o8},     32'd1);
        chk("rst_busy8",  {31'd0, busy8},  32'd0);
        chk("rst_done8",  {31'd0, done8},  32'd0);
        chk("rst_ackok8", {31'd0, ackok8}, 32'd0);
        chk("rst_rx8",    {24'd0, rx8},    32'd0);
        chk("rst_osda16", {31'd0, o16},    32'd1);
        chk("rst_rx16",   {16'd0, rx16},   32'd0);

        // Transmit 7B, go and dbit together: first bit must not advance
        mode = 1'b0; data8 = 8'h7B; go8 = 1'b1; dbit8 = 1'b1;
        step();
        go8 = 1'b0; dbit8 = 1'b0; data8 = 8'h00;
        chk("tx_busy_start", {31'd0, busy8}, 32'd1);
        shift8(8'b0111_1011, 8'h00, 0, 8);
        chk("tx_ack_release", {31'd0, o8}, 32'd1);
        chk("tx_ack_busy", {31'd0, busy8}, 32'd1);
        chk("tx_no_early_done", {31'd0, done8}, 32'd0);
        iSDA = 1'b0; dbit8 = 1'b1;
        step();
        dbit8 = 1'b0; iSDA = 1'b1;
        chk("tx_done", {31'd0, done8}, 32'd1);
        chk("tx_done_busy", {31'd0, busy8}, 32'd0);
        chk("tx_ackok", {31'd0, ackok8}, 32'd1);
        chk("tx_done_osda", {31'd0, o8}, 32'd1);
        step();
        chk("tx_done_once", {31'd0, done8}, 32'd0);
        chk("tx_ackok_held", {31'd0, ackok8}, 32'd1);

        // Receive A5 with ACK
        mode = 1'b1; ack_en = 1'b1; go8 = 1'b1;
        step();
        go8 = 1'b0;
        chk("rx_ackok_cleared", {31'd0, ackok8}, 32'd0);
        shift8(8'hFF, 8'hA5, 0, 8);
        chk("rx_data_a5", {24'd0, rx8}, 32'h0000_00A5);
        chk("rx_ack_drive", {31'd0, o8}, 32'd0);
        iSDA = 1'b1; dbit8 = 1'b1;
        step();
        dbit8 = 1'b0;
        chk("rx_done", {31'd0, done8}, 32'd1);
        chk("rx_done_osda", {31'd0, o8}, 32'd1);
        step();
        chk("rx_done_once", {31'd0, done8}, 32'd0);
        chk("rx_data_held", {24'd0, rx8}, 32'h0000_00A5);

        // go mid-SHIFT with new Data is ignored
        mode = 1'b0; data8 = 8'h3C; go8 = 1'b1;
        step();
        go8 = 1'b0;
        shift8(8'h3C, 8'h00, 0, 2);
        data8 = 8'hFF; go8 = 1'b1;
        step();
        go8 = 1'b0;
        shift8(8'h3C, 8'h00, 2, 8);
        chk("midgo_ack_busy", {31'd0, busy8}, 32'd1);
        iSDA = 1'b1; dbit8 = 1'b1;
        step();
        dbit8 = 1'b0;
        chk("midgo_done", {31'd0, done8}, 32'd1);
        chk("midgo_nack", {31'd0, ackok8}, 32'd0);
        step();

        // rst after the 3rd dbit
        mode = 1'b0; data8 = 8'hC3; go8 = 1'b1;
        step();
        go8 = 1'b0;
        shift8(8'hC3, 8'h00, 0, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, busy8}, 32'd0);
        chk("rst_mid_osda", {31'd0, o8}, 32'd1);
        chk("rst_mid_done", {31'd0, done8}, 32'd0);
        chk("rst_mid_rx", {24'd0, rx8}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            dbit8 = 1'b1;
            step();
            dbit8 = 1'b0;
            chk("idle_dbit_busy", {31'd0, busy8}, 32'd0);
            chk("idle_dbit_done", {31'd0, done8}, 32'd0);
        end

        // Abort in ACK of a NACKed receive
        mode = 1'b1; ack_en = 1'b0; go8 = 1'b1;
        step();
        go8 = 1'b0;
        shift8(8'hFF, 8'h5A, 0, 8);
        chk("ab_rx_data", {24'd0, rx8}, 32'h0000_005A);
        chk("ab_nack_drive", {31'd0, o8}, 32'd1);
        chk("ab_in_ack", {31'd0, busy8}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", {31'd0, busy8}, 32'd0);
        chk("ab_osda", {31'd0, o8}, 32'd1);
        chk("ab_no_done", {31'd0, done8}, 32'd0);
        chk("ab_rx_kept", {24'd0, rx8}, 32'h0000_005A);
        step();
        chk("ab_no_done_later", {31'd0, done8}, 32'd0);

        // 16-bit LSB-first transmit of BEEF, slave NACKs
        mode = 1'b0; data16 = 16'hBEEF; go16 = 1'b1;
        step();
        go16 = 1'b0; data16 = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("w16_bit%0d", i), {31'd0, o16}, {31'd0, exp16[i]});
            chk("w16_busy", {31'd0, busy16}, 32'd1);
            dbit16 = 1'b1;
            step();
            dbit16 = 1'b0;
        end
        chk("w16_ack_release", {31'd0, o16}, 32'd1);
        chk("w16_ack_busy", {31'd0, busy16}, 32'd1);
        iSDA = 1'b1; dbit16 = 1'b1;
        step();
        dbit16 = 1'b0;
        chk("w16_done", {31'd0, done16}, 32'd1);
        chk("w16_nack", {31'd0, ackok16}, 32'd0);
        step();
        chk("w16_done_once", {31'd0, done16}, 32'd0);
        chk("w16_idle", {31'd0, busy16}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_shift_unit.md
I2C_SHIFT_UNIT -- requirements
Module: i2c_shift_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, word width in bits; legal range 2..32.
REQ-002 SHALL provide parameter MSB_FIRST, default 1, bit order (1 = MSB first, 0 = LSB first).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port go  input  1  start request; sampled only in IDLE.
REQ-006 SHALL have port dbit  input  1  one-cycle bit strobe from the bit-timing unit.
REQ-007 SHALL have port mode  input  1  0 = transmit, 1 = receive; latched on accepted go.
REQ-008 SHALL have port ack_en  input  1  receive only: 1 = drive ACK, 0 = drive NACK; latched on go.
REQ-009 SHALL have port abort  input  1  synchronous abort request.
REQ-010 SHALL have port Data  input  DATA_W  transmit word; latched on go.
REQ-011 SHALL have port iSDA  input  1  sampled SDA line.
REQ-012 SHALL have port oSDA  output  1  SDA drive value (1 = released), registered.
REQ-013 SHALL have port rx_data  output  DATA_W  last received word, registered.
REQ-014 SHALL have port busy  output  1  high in SHIFT and ACK.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port ack_ok  output  1  transmit: 1 if slave ACKed; held until next go.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, ACK, DONE.
- IDLE -> SHIFT on go.
- SHIFT -> ACK on the DATA_W-th dbit.
- ACK -> DONE on the next dbit.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 SHALL, on go in IDLE, latch Data, mode and ack_en, load bit counter = DATA_W-1, clear ack_ok, and present the first bit on oSDA in the next cycle (transmit).
REQ-019 SHALL, in SHIFT transmit, hold the current bit on oSDA until dbit; each dbit advances one bit in MSB_FIRST order.
REQ-020 SHALL, in SHIFT receive, hold oSDA = 1 and shift iSDA into the receive register on each dbit.
REQ-021 SHALL, in ACK transmit, hold oSDA = 1 and on dbit set ack_ok = ~iSDA.
REQ-022 SHALL, in ACK receive, drive oSDA = ~ack_en_latched and update rx_data from the receive register on entry to ACK.
REQ-023 SHALL assert done for exactly the DONE cycle and drive oSDA = 1 in IDLE and DONE.
REQ-024 SHALL ignore go outside IDLE, and ignore dbit in IDLE and DONE.
REQ-025 SHALL give go priority over dbit when both are high in IDLE; that dbit does not advance a bit.
REQ-026 SHALL, on abort in any state, go to IDLE next cycle with oSDA = 1 and no done pulse; rx_data and ack_ok keep their values.
REQ-027 SHALL use a bit counter of width clog2(DATA_W) that never wraps; terminal count 0 selects the ACK transition.

Reset
REQ-028 SHALL, on rst, force state = IDLE, oSDA = 1, busy = 0, done = 0, ack_ok = 0, rx_data = 0, and counter = 0, including mid-transfer.
REQ-029 SHALL give rst priority over abort, go and dbit.

Structure
REQ-030 SHALL take the state encoding and the constants SDA_REL = 1 and SDA_ACK = 0 from the shared package i2c_pkg.
REQ-031 SHALL be a single module with no sub-module; the counter and shift registers are inline.

Verification
REQ-032 SHALL cover: DATA_W = 8 transmit, Data = 8'h7B, iSDA = 0 in ACK -> oSDA sequence 0,1,1,1,1,0,1,1 per dbit, ack_ok = 1, one done pulse.
REQ-033 SHALL cover: receive with iSDA pattern 8'hA5 and ack_en = 1 -> rx_data = 8'hA5, oSDA = 0 during ACK, done pulse.
REQ-034 SHALL cover: DATA_W = 16, MSB_FIRST = 0, transmit 16'hBEEF with iSDA = 1 in ACK -> LSB-first bits appear on oSDA, ack_ok = 0.
REQ-035 SHALL cover: rst asserted after the 3rd dbit -> next cycle IDLE, oSDA = 1, busy = 0, no done pulse.
REQ-036 SHALL cover: go pulsed mid-SHIFT with a new Data value -> ignored, original word completes unchanged.
REQ-037 SHALL cover: abort in ACK -> IDLE next cycle, no done pulse, rx_data unchanged.
